n_gate_inertial: RTL and testbench

- Clocked, synthesizable, multi-channel successor to the analog-core behavioural gate cells.
- Each channel computes a selectable N-input logic function.
- Each channel output follows that function through a programmable inertial delay, counted in clock cycles, plus optional LFSR-driven pseudo-random jitter.
- Used in emulation/FPGA builds of the analog core, where `#` delays and `real` jitter are not available; config arrives over a valid/ready port from the test/JTAG layer.

---
 rtl/n_gate_pkg.sv | 53 +++++
 rtl/n_gate_chan.sv | 100 ++++++++++
 rtl/n_gate_inertial.sv | 69 ++++++
 tb/tb_n_gate_inertial.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/n_gate_pkg.sv
// Shared types for the clocked inertial gate array: function codes, channel
// states, packed config word and the LFSR step.
package n_gate_pkg;

  typedef enum logic [2:0] {
    GF_NOR  = 3'd0,
    GF_OR   = 3'd1,
    GF_NAND = 3'd2,
    GF_AND  = 3'd3,
    GF_XOR  = 3'd4,
    GF_XNOR = 3'd5
  } gate_func_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } chan_state_t;

  // Galois form of x^16+x^14+x^13+x^11, shifting right.
  localparam logic [15:0] LFSR_TAPS     = 16'hB400;
  localparam logic [15:0] LFSR_SEED_DEF = 16'hACE1;

  // Config word carries td at a fixed maximum width so the struct does not
  // depend on the top-level DLY_W parameter.
  localparam int TD_MAX_W = 16;

  typedef struct packed {
    gate_func_t             func;
    logic [TD_MAX_W-1:0]    td;
    logic                   rj_en;
  } cfg_t;

  localparam cfg_t CFG_RESET = '{func: GF_NOR, td: TD_MAX_W'(1), rj_en: 1'b0};

  // Codes 6 and 7 have no gate of their own and fall back to NOR.
  function automatic gate_func_t decode_func(input logic [2:0] code);
    gate_func_t f;
    case (code)
      3'd1:    f = GF_OR;
      3'd2:    f = GF_NAND;
      3'd3:    f = GF_AND;
      3'd4:    f = GF_XOR;
      3'd5:    f = GF_XNOR;
      default: f = GF_NOR;
    endcase
    return f;
  endfunction

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

endpackage

// File: rtl/n_gate_chan.sv
// One gate channel: N-input function, inertial delay counter and IDLE/PEND FSM.
// Output moves on the D-th consecutive edge that saw f != out; shorter pulses are dropped.
module n_gate_chan
  import n_gate_pkg::*;
#(
  parameter int N_IN  = 2,
  parameter int DLY_W = 6,
  parameter int RJ_W  = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_IN-1:0]     in_i,
  input  gate_func_t          func_i,
  input  logic [TD_MAX_W-1:0] td_i,
  input  logic [RJ_W-1:0]     jit_i,
  output logic                out_o,
  output logic                busy_o
);

  localparam int DW = DLY_W + 1;
  localparam logic [DW-1:0] D_ONE = DW'(1);

  chan_state_t           state_q, state_d;
  logic [DW-1:0]         cnt_q, cnt_d;
  logic [DW-1:0]         d_q, d_d;
  logic                  out_q, out_d;

  logic                  f;
  logic [TD_MAX_W:0]     d_sum;
  logic [DW-1:0]         d_clip;
  logic [DW-1:0]         d_new;
  logic [DW-1:0]         cnt_inc;

  always_comb begin
    case (func_i)
      GF_OR:   f = |in_i;
      GF_NAND: f = ~&in_i;
      GF_AND:  f = &in_i;
      GF_XOR:  f = ^in_i;
      GF_XNOR: f = ~^in_i;
      default: f = ~|in_i;
    endcase
  end

  // Saturate if a td code wider than DLY_W ever reaches the channel.
  always_comb begin
    d_sum  = {1'b0, td_i} + (TD_MAX_W + 1)'(jit_i);
    d_clip = (|d_sum[TD_MAX_W:DW]) ? '1 : d_sum[DW-1:0];
    d_new  = (d_clip == '0) ? D_ONE : d_clip;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    d_d     = d_q;
    out_d   = out_q;
    cnt_inc = cnt_q + D_ONE;
    case (state_q)
      ST_IDLE: begin
        if (f != out_q) begin
          d_d   = d_new;
          cnt_d = D_ONE;
          if (d_new == D_ONE) out_d = f;
          else                state_d = ST_PEND;
        end
      end
      ST_PEND: begin
        if (f == out_q) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == d_q) begin
            out_d   = f;
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      d_q     <= '0;
      out_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      d_q     <= d_d;
      out_q   <= out_d;
    end
  end

  assign out_o  = out_q;
  assign busy_o = (state_q == ST_PEND);

endmodule

// File: rtl/n_gate_inertial.sv
// Multi-channel inertial gate array: shared LFSR jitter source and config
// register; config is accepted only while no channel has a pending transition.
module n_gate_inertial
  import n_gate_pkg::*;
#(
  parameter int          N_CH      = 4,
  parameter int          N_IN      = 2,
  parameter int          DLY_W     = 6,
  parameter int          RJ_W      = 3,
  parameter logic [15:0] LFSR_SEED = LFSR_SEED_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_CH*N_IN-1:0]   in,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  input  logic [2:0]             cfg_func,
  input  logic [DLY_W-1:0]       cfg_td,
  input  logic                   cfg_rj_en,
  output logic [N_CH-1:0]        out,
  output logic [N_CH-1:0]        busy
);

  logic [15:0] lfsr_q, lfsr_d;
  cfg_t        cfg_q, cfg_d;
  logic        xfer;

  assign cfg_ready = ~|busy;
  assign xfer      = cfg_valid & cfg_ready;

  always_comb begin
    lfsr_d = lfsr_next(lfsr_q);
    cfg_d  = cfg_q;
    if (xfer) begin
      cfg_d = '{func: decode_func(cfg_func), td: TD_MAX_W'(cfg_td), rj_en: cfg_rj_en};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= LFSR_SEED;
      cfg_q  <= CFG_RESET;
    end else begin
      lfsr_q <= lfsr_d;
      cfg_q  <= cfg_d;
    end
  end

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_chan
    logic [RJ_W-1:0] jit;
    assign jit = cfg_q.rj_en ? lfsr_q[gi*RJ_W +: RJ_W] : '0;

    n_gate_chan #(
      .N_IN  (N_IN),
      .DLY_W (DLY_W),
      .RJ_W  (RJ_W)
    ) u_chan (
      .clk    (clk),
      .rst    (rst),
      .in_i   (in[gi*N_IN +: N_IN]),
      .func_i (cfg_q.func),
      .td_i   (cfg_q.td),
      .jit_i  (jit),
      .out_o  (out[gi]),
      .busy_o (busy[gi])
    );
  end

endmodule

// File: tb/tb_n_gate_inertial.sv
// Directed bench for n_gate_inertial: reset, delay/rejection timing, config
// handshake, jitter against a reference LFSR, reset priority and function codes.
module tb_n_gate_inertial;

  logic       clk;
  logic       rst;
  logic [7:0] in_v;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [2:0] cfg_func;
  logic [5:0] cfg_td;
  logic       cfg_rj_en;
  logic [3:0] out_v;
  logic [3:0] busy_v;

  int vec  = 0;
  int miss = 0;

  logic [15:0] m_lfsr;
  logic [3:0]  cur;

  n_gate_inertial #(
    .N_CH      (4),
    .N_IN      (2),
    .DLY_W     (6),
    .RJ_W      (3),
    .LFSR_SEED (16'hACE1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in        (in_v),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_func  (cfg_func),
    .cfg_td    (cfg_td),
    .cfg_rj_en (cfg_rj_en),
    .out       (out_v),
    .busy      (busy_v)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference x^16+x^14+x^13+x^11 Galois LFSR, restarted by rst.
  always @(posedge clk) begin
    if (rst) m_lfsr <= 16'hACE1;
    else     m_lfsr <= (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp)
      else begin
        miss++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  task automatic do_cfg(input logic [2:0] f, input logic [5:0] td, input logic rj);
    cfg_func  = f;
    cfg_td    = td;
    cfg_rj_en = rj;
    cfg_valid = 1'b1;
    chk("cfg_ready_before_xfer", {31'd0, cfg_ready}, 32'd1);
    step(1);
    cfg_valid = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    in_v      = 8'h00;
    cfg_valid = 1'b0;
    cfg_func  = 3'd0;
    cfg_td    = 6'd0;
    cfg_rj_en = 1'b0;
    cur       = 4'b0000;

    // Reset state
    step(2);
    chk("rst_out", {28'd0, out_v}, 32'h0);
    chk("rst_busy", {28'd0, busy_v}, 32'h0);
    chk("rst_ready", {31'd0, cfg_ready}, 32'd1);

    // Default NOR, td=1: all outputs rise on the first edge out of reset
    rst = 1'b0;
    step(1);
    chk("nor_default_out", {28'd0, out_v}, 32'hF);
    chk("nor_default_busy", {28'd0, busy_v}, 32'h0);
    in_v[1:0] = 2'b01;
    step(1);
    chk("nor_ch0_01", {28'd0, out_v}, 32'hE);

    // AND, td=5: the function change alone starts a 5-cycle fall on every channel
    in_v = 8'h00;
    do_cfg(3'd3, 6'd5, 1'b0);
    chk("xfer_edge_old_cfg", {28'd0, out_v}, 32'hF);
    step(1);
    chk("func_change_busy", {28'd0, busy_v}, 32'hF);
    chk("func_change_ready", {31'd0, cfg_ready}, 32'd0);
    step(3);
    chk("func_change_hold", {28'd0, out_v}, 32'hF);
    step(1);
    chk("func_change_out", {28'd0, out_v}, 32'h0);
    chk("func_change_idle", {28'd0, busy_v}, 32'h0);

    // ch1 rises on the 5th sample
    in_v[3:2] = 2'b11;
    step(1);
    chk("ch1_busy_k", {28'd0, busy_v}, 32'h2);
    step(3);
    chk("ch1_busy_k3", {28'd0, busy_v}, 32'h2);
    chk("ch1_out_k3", {28'd0, out_v}, 32'h0);
    step(1);
    chk("ch1_out_k4", {28'd0, out_v}, 32'h2);
    chk("ch1_idle_k4", {28'd0, busy_v}, 32'h0);

    // Inertial rejection of a 3-cycle pulse
    in_v[3:2] = 2'b00;
    step(5);
    chk("ch1_fall", {28'd0, out_v}, 32'h0);
    in_v[3:2] = 2'b11;
    step(3);
    chk("pulse_busy", {28'd0, busy_v}, 32'h2);
    in_v[3:2] = 2'b00;
    step(1);
    chk("pulse_cancel_busy", {28'd0, busy_v}, 32'h0);
    chk("pulse_cancel_out", {28'd0, out_v}, 32'h0);
    step(5);
    chk("pulse_rejected", {28'd0, out_v}, 32'h0);

    // Config held off while ch2 is pending; new td=2 applies to the next transition
    in_v[5:4] = 2'b11;
    step(1);
    chk("ch2_busy", {28'd0, busy_v}, 32'h4);
    chk("ch2_ready_low", {31'd0, cfg_ready}, 32'd0);
    cfg_func  = 3'd3;
    cfg_td    = 6'd2;
    cfg_rj_en = 1'b0;
    cfg_valid = 1'b1;
    step(3);
    chk("held_ready_low", {31'd0, cfg_ready}, 32'd0);
    step(1);
    chk("ch2_old_td_out", {28'd0, out_v}, 32'h4);
    chk("ready_after_busy", {31'd0, cfg_ready}, 32'd1);
    step(1);
    cfg_valid = 1'b0;
    in_v[5:4] = 2'b00;
    step(1);
    chk("new_td_busy", {28'd0, busy_v}, 32'h4);
    step(1);
    chk("new_td_out", {28'd0, out_v}, 32'h0);
    chk("new_td_idle", {28'd0, busy_v}, 32'h0);

    // Jitter: td=4 plus this cycle's LFSR slice, rotating across channels
    do_cfg(3'd3, 6'd4, 1'b1);
    for (int t = 0; t < 20; t++) begin
      int ch;
      int exp_d;
      int n;
      ch    = t % 4;
      exp_d = 4 + int'(m_lfsr[ch*3 +: 3]);
      cur[ch] = ~cur[ch];
      in_v[ch*2 +: 2] = cur[ch] ? 2'b11 : 2'b00;
      n = 0;
      do begin
        step(1);
        n++;
      end while (out_v[ch] !== cur[ch] && n < 40);
      chk($sformatf("jitter_D_t%0d", t), n, exp_d);
    end

    // td=0 clamps to D=1
    do_cfg(3'd3, 6'd0, 1'b0);
    in_v[7:6] = 2'b00;
    step(1);
    chk("td0_out", {28'd0, out_v}, 32'h7);
    chk("td0_busy", {28'd0, busy_v}, 32'h0);

    // Reset during PEND with td=10, config request ignored
    do_cfg(3'd3, 6'd10, 1'b0);
    in_v[1:0] = 2'b00;
    step(1);
    chk("td10_busy", {28'd0, busy_v}, 32'h1);
    step(2);
    rst       = 1'b1;
    cfg_func  = 3'd1;
    cfg_td    = 6'd7;
    cfg_rj_en = 1'b1;
    cfg_valid = 1'b1;
    step(1);
    chk("rst_mid_out", {28'd0, out_v}, 32'h0);
    chk("rst_mid_busy", {28'd0, busy_v}, 32'h0);
    chk("rst_mid_ready", {31'd0, cfg_ready}, 32'd1);
    step(1);
    chk("rst_hold_out", {28'd0, out_v}, 32'h0);
    rst       = 1'b0;
    cfg_valid = 1'b0;
    in_v      = 8'b11_10_01_00;
    step(1);
    chk("post_rst_nor_td1", {28'd0, out_v}, 32'h1);

    // Function code sweep with td=1
    do_cfg(3'd4, 6'd1, 1'b0);
    step(1);
    chk("func_xor", {28'd0, out_v}, 32'h6);
    do_cfg(3'd5, 6'd1, 1'b0);
    step(1);
    chk("func_xnor", {28'd0, out_v}, 32'h9);
    do_cfg(3'd2, 6'd1, 1'b0);
    step(1);
    chk("func_nand", {28'd0, out_v}, 32'h7);
    do_cfg(3'd1, 6'd1, 1'b0);
    step(1);
    chk("func_or", {28'd0, out_v}, 32'hE);
    do_cfg(3'd6, 6'd1, 1'b0);
    step(1);
    chk("func_code6_nor", {28'd0, out_v}, 32'h1);
    do_cfg(3'd3, 6'd1, 1'b0);
    step(1);
    chk("func_and", {28'd0, out_v}, 32'h8);
    do_cfg(3'd7, 6'd1, 1'b0);
    step(1);
    chk("func_code7_nor", {28'd0, out_v}, 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
